io_ccff_loader: RTL
===================

Name: io_ccff_loader

Overview:
- Configuration-chain controller for one I/O grid tile: a chain of NUM_SUBTILES I/O subtiles, each holding BITS_PER_SUBTILE configuration flops.
- Accepts the tile bitstream as words over a valid/ready handshake, serialises it onto ccff_head, and gates chain shifting via ccff_shift_en.
- After loading, rotates a shadow copy through the chain and checks ccff_tail (non-destructive readback), then asserts cfg_done.
- Sits between the fabric-level bitstream source and the tile's ccff_head/ccff_tail/cfg_done pins.

Parameters:
- NUM_SUBTILES, 8, I/O subtiles in the chain.
- BITS_PER_SUBTILE, 1, configuration bits per subtile.
- WORD_W, 8, input bitstream word width.
- CHAIN_LEN, NUM_SUBTILES*BITS_PER_SUBTILE, derived; total chain bits (local constant).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- prog_reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERROR.
- word_valid  in  1  bitstream word available.
- word_data  in  WORD_W  bitstream word; LSB is shifted first.
- word_ready  out  1  word accepted when word_valid && word_ready.
- ccff_head  out  1  serial data into the chain.
- ccff_tail  in  1  serial data out of the chain.
- ccff_shift_en  out  1  chain shifts on a rising edge only when this is 1 (drives the external clock gate).
- busy  out  1  high in LOAD or VERIFY.
- cfg_done  out  1  configuration complete and verified; level signal.
- cfg_error  out  1  readback mismatch; level signal.

Behaviour:
- Reset: state IDLE; all outputs 0; bit counter 0; shadow register 0; serialiser empty.
- Async assert of prog_reset mid-operation aborts immediately to IDLE. Chain contents are then undefined; a new start is required.
- IDLE/DONE/ERROR + start -> LOAD. On this transition: clear cfg_done and cfg_error, bit counter := 0, serialiser empty.
- LOAD, serialiser:
  - word_ready = 1 only when the serialiser is empty and fewer than CHAIN_LEN bits have been shifted.
  - On acceptance, the word is captured. From the next cycle it emits one bit per cycle, LSB first.
  - When a word is held, ccff_head = current bit, ccff_shift_en = 1, shadow[cnt] := bit, cnt += 1.
  - Empty serialiser (source stalls): ccff_shift_en = 0 and the chain holds.
  - Words never overlap. Bits of the final word beyond CHAIN_LEN are discarded, with ccff_shift_en = 0 for them.
- LOAD -> VERIFY in the cycle after cnt reaches CHAIN_LEN; cnt := 0 on entry.
- VERIFY:
  - Each cycle: ccff_head = shadow[cnt], ccff_shift_en = 1.
  - ccff_tail is sampled before the shift edge and compared with shadow[cnt]. Chain depth is CHAIN_LEN, so the bit loaded first emerges first.
  - After CHAIN_LEN shifts the chain holds the original contents again.
  - Any mismatch sets a sticky mismatch flag.
- VERIFY end, at cnt == CHAIN_LEN:
  - flag clear -> DONE, cfg_done = 1.
  - flag set -> ERROR, cfg_error = 1.
- ccff_shift_en = 0 in IDLE, DONE and ERROR. word_ready = 0 outside LOAD.
- Latency: best case with word_valid constantly high is CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN + 1 cycles from start to cfg_done.
- start while busy: ignored.
- start in the same cycle as the final VERIFY shift: ignored; completion is reported normally.
- Width rules:
  - Counter width = $clog2(CHAIN_LEN+1).
  - Serialiser index width = $clog2(WORD_W).
  - CHAIN_LEN = 1 and WORD_W = 1 must be legal.

Decomposition:
- Shared package io_cfg_pkg:
  - state enum {IDLE, LOAD, VERIFY, DONE, ERROR}.
  - function cfg_cnt_w(len) returning the counter width.
- One sub-module, io_cfg_serializer: captures a word and emits bits LSB-first. Interface: word handshake in, bit/bit_valid out, plus a flush input.
- The FSM, shadow register and comparator live in io_ccff_loader.

Test Plan:
- Clean load (defaults, bench chain model of 8 flops): start, word 0xA5 with valid held high.
  - Expect ccff_head sequence 1,0,1,0,0,1,0,1.
  - Expect ccff_shift_en high for 8 + 8 cycles.
  - Expect cfg_done = 1 at cycle 18 after start; model chain = 0xA5; cfg_error = 0.
- Source stall: word_valid low for 5 cycles after start, then 0x3C.
  - Expect ccff_shift_en = 0 during the stall.
  - Expect cfg_done 5 cycles later than the clean case; chain = 0x3C.
- Readback fault: bench forces ccff_tail stuck at 0, load 0xFF -> expect cfg_error = 1, cfg_done = 0, state ERROR after 8 VERIFY shifts.
- Partial word (NUM_SUBTILES = 3, WORD_W = 8): load 0xFE -> only 3 shifts (0,1,1); chain = 3'b110; bits 3..7 dropped; word_ready never reasserted.
- Reset mid-LOAD: assert prog_reset after 4 shifts -> same-cycle outputs all 0, state IDLE. A following start plus 0x5A completes with cfg_done = 1.
- start ignored while busy: pulse start during VERIFY -> no restart, cfg_done at the normal cycle. A start pulse in DONE clears cfg_done on the next cycle and re-enters LOAD.

Source files
------------

// File: rtl/io_cfg_pkg.sv
// Shared types and width helpers for the I/O tile configuration-chain loader.
package io_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVerify,
    StDone,
    StError
  } cfg_state_e;

  // Bit counter must be able to hold the value len itself, not just len-1.
  function automatic int unsigned cfg_cnt_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  // Serialiser bit index; kept at least one bit wide so WORD_W = 1 stays legal.
  function automatic int unsigned cfg_idx_w(input int unsigned word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/io_cfg_serializer.sv
// Word-to-bit serialiser: captures one word when empty and emits it LSB first,
// one bit per cycle, starting the cycle after capture. Never overlaps words.
module io_cfg_serializer import io_cfg_pkg::*; #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              accept_en_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_data_i,
  output logic              word_ready_o,
  output logic              bit_o,
  output logic              bit_valid_o
);

  localparam int unsigned IdxW = cfg_idx_w(WORD_W);

  logic              holding_q, holding_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  // Handshake and bit outputs come straight from the holding register.
  always_comb begin
    word_ready_o = accept_en_i && !holding_q;
    bit_valid_o  = holding_q;
    bit_o        = data_q[0];
  end

  // Capture / shift-out / flush sequencing.
  always_comb begin
    holding_d = holding_q;
    data_d    = data_q;
    idx_d     = idx_q;
    if (flush_i) begin
      holding_d = 1'b0;
      idx_d     = '0;
    end else if (holding_q) begin
      data_d = data_q >> 1;
      if (idx_q == IdxW'(WORD_W - 1)) begin
        holding_d = 1'b0;
        idx_d     = '0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end else if (word_valid_i && word_ready_o) begin
      data_d    = word_data_i;
      holding_d = 1'b1;
      idx_d     = '0;
    end
  end

  // Serialiser state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      holding_q <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
    end else begin
      holding_q <= holding_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: rtl/io_ccff_loader.sv
// Configuration-chain controller for one I/O tile: serialises the bitstream
// onto ccff_head, then rotates a shadow copy through the chain and checks
// ccff_tail so the readback leaves the chain contents unchanged.
module io_ccff_loader import io_cfg_pkg::*; #(
  parameter int unsigned NUM_SUBTILES     = 8,
  parameter int unsigned BITS_PER_SUBTILE = 1,
  parameter int unsigned WORD_W           = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error
);

  localparam int unsigned CHAIN_LEN = NUM_SUBTILES * BITS_PER_SUBTILE;
  localparam int unsigned CntW      = cfg_cnt_w(CHAIN_LEN);

  cfg_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic                 mismatch_q, mismatch_d;

  logic ser_flush;
  logic ser_accept_en;
  logic ser_bit;
  logic ser_bit_valid;
  logic shadow_bit;

  io_cfg_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk_i        (prog_clk),
    .rst_i        (prog_reset),
    .flush_i      (ser_flush),
    .accept_en_i  (ser_accept_en),
    .word_valid_i (word_valid),
    .word_data_i  (word_data),
    .word_ready_o (word_ready),
    .bit_o        (ser_bit),
    .bit_valid_o  (ser_bit_valid)
  );

  // Shadow bit at the current counter position (0 once the counter hits CHAIN_LEN).
  always_comb begin
    shadow_bit = 1'b0;
    for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
      if (cnt_q == CntW'(i)) shadow_bit = shadow_q[i];
    end
  end

  // Next-state, counter, shadow and chain-drive logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    mismatch_d    = mismatch_q;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    ser_flush     = 1'b0;
    ser_accept_en = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StLoad;
          cnt_d      = '0;
          mismatch_d = 1'b0;
          ser_flush  = 1'b1;
        end
      end

      StLoad: begin
        ser_accept_en = (cnt_q < CntW'(CHAIN_LEN));
        if (ser_bit_valid && (cnt_q < CntW'(CHAIN_LEN))) begin
          ccff_head     = ser_bit;
          ccff_shift_en = 1'b1;
          for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
            if (cnt_q == CntW'(i)) shadow_d[i] = ser_bit;
          end
          if (cnt_q == CntW'(CHAIN_LEN - 1)) begin
            // Last chain bit: any leftover bits of this word are dropped.
            state_d   = StVerify;
            cnt_d     = '0;
            ser_flush = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StVerify: begin
        if (cnt_q < CntW'(CHAIN_LEN)) begin
          // Re-inject the shadow bit so the chain ends up with its original contents.
          ccff_head     = shadow_bit;
          ccff_shift_en = 1'b1;
          if (ccff_tail != shadow_bit) mismatch_d = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end else begin
          state_d = mismatch_q ? StError : StDone;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy      = (state_q == StLoad) || (state_q == StVerify);
    cfg_done  = (state_q == StDone);
    cfg_error = (state_q == StError);
  end

  // Controller state register.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shadow_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      mismatch_q <= mismatch_d;
    end
  end

endmodule
